vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Mode controller for the VGA timing counter. Holds a table of four timing modes and drives the counter's ten timing-parameter inputs (hlimit/hsync/hbp/hfp/hlenght, vlimit/vsync/vbp/vfp/vlenght). Accepts mode-change requests through a req/ack handshake and applies a new mode only at a frame boundary. After each switch it forces blanking for a configurable number of frames so the monitor can resynchronise.

## Interface
- FRAME_SETTLE, 2: number of frame boundaries during which `blank` stays high after a mode is applied (0..15).
- DEFAULT_MODE, 0: mode loaded at reset (0..3).

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  reset, asynchronous, active-high
- mode_req  in  1  mode-change request; held by the requester until acked
- mode_sel  in  2  requested mode, sampled with mode_req
- mode_ack  out  1  one-cycle pulse: request accepted
- mode_busy  out  1  high in PEND or SETTLE
- cur_mode  out  2  mode currently driven on the parameter outputs
- in_vertical  in  10  counter's current vertical position (feedback)
- hlimit, hsync, hbp, hfp, hlenght  out  10 each  horizontal timing to the counter
- vlimit, vsync, vbp, vfp, vlenght  out  10 each  vertical timing to the counter
- blank  out  1  high forces the colour path to black

With VGA_CTRL_PROG_EN only:
- wr_en  in  1
- wr_addr  in  4
- wr_data  in  10

## Operation
Mode table, as {limit, sync, bp, len, fp}:
- 0: H {799,96,48,640,16}, V {524,2,33,480,10}
- 1: H as mode 0, V {448,2,60,350,37}
- 2: H as mode 0, V {448,2,35,400,12}
- 3: H {27,4,4,16,4}, V {6,1,1,4,1} (small simulation mode)

Frame boundary (`fb`):
- Registered `prev_v` holds the last in_vertical.
- fb = (in_vertical == 0) && (prev_v != 0). It is a single-cycle event.

FSM states are RUN, PEND and SETTLE.
- RUN, mode_req=1:
  - mode_ack=1 on the next cycle; mode_sel is latched as `next_mode`.
  - If next_mode == cur_mode, stay in RUN.
  - Otherwise go to PEND.
- PEND: old parameters stay on the outputs and blank=0. On fb:
  - load next_mode's parameters into the output registers;
  - set cur_mode = next_mode and clear the settle counter;
  - go to SETTLE.
- SETTLE:
  - blank=1; each fb increments the 4-bit settle counter.
  - Go to RUN on the cycle after the counter reaches FRAME_SETTLE.
  - FRAME_SETTLE=0 means SETTLE lasts exactly one cycle.
- mode_req in PEND or SETTLE is ignored with no ack. The requester keeps holding and is acked once the FSM is back in RUN.
- All outputs are registered. Parameter outputs change only on the PEND→SETTLE edge, or at reset.

Reset (asynchronous, takes effect immediately; also valid mid-PEND or mid-SETTLE):
- state=SETTLE, settle counter=0, cur_mode=DEFAULT_MODE
- parameters = DEFAULT_MODE's table
- blank=1, mode_busy=1, mode_ack=0, prev_v=0
- Any pending request is discarded.

## Timing
- Ack latency: 1 cycle after mode_req is sampled high in RUN.
- Parameter switch occurs on the clock edge where fb is seen, so the new values are visible in that frame's first line.
- A full switch lasts at most one frame in PEND plus FRAME_SETTLE frames in SETTLE.
- blank rises on the same edge the parameters change, and falls on the edge SETTLE→RUN.
- mode_busy = (state != RUN), registered with the state.

## Configuration
- VGA_CTRL_PROG_EN defined:
  - Mode 3 is a writable shadow register set, reset to the mode 3 values in the table above.
  - wr_en=1 writes wr_data to one field per wr_addr: 0..4 = H limit, sync, bp, fp, len; 5..9 = V limit, sync, bp, fp, len. Addresses 10..15 are ignored.
  - Writes never touch the live outputs. They take effect at the next switch into mode 3; re-requesting mode 3 while already in mode 3 does not reload.
- VGA_CTRL_PROG_EN undefined: mode 3 is fixed, and the wr_* ports and their registers are absent.

## Test plan
- Reset with DEFAULT_MODE=0, FRAME_SETTLE=2, drive in_vertical from a model counter → hlimit=799, vlimit=524, blank=1 until the second fb, then blank=0 and mode_busy=0.
- In RUN, mode_req=1, mode_sel=3 → mode_ack pulses for 1 cycle. Parameters stay at mode 0 until in_vertical goes 524→0, then hlimit=27, vlimit=6, cur_mode=3, blank=1.
- mode_req asserted again during SETTLE → no ack until RUN; ack arrives on the first RUN cycle +1.
- Request mode_sel == cur_mode → mode_ack pulses, state stays RUN, blank stays 0, outputs unchanged.
- Assert rst_in mid-PEND (pending mode 2 from mode 0) → outputs immediately revert to mode DEFAULT_MODE with blank=1; mode 2 is never applied.
- PROG_EN: write addr 0 = 31 while in mode 0, then switch to mode 3 → hlimit=31 after fb; rewrite while in mode 3 → hlimit remains 31.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// Mode controller for the VGA timing counter: four-entry timing table, frame-aligned switching
// and post-switch blanking. Define VGA_CTRL_PROG_EN to make mode 3 a writable register set.
module vga_timing_ctrl #(
    parameter int unsigned FRAME_SETTLE = 2,
    parameter int unsigned DEFAULT_MODE = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic        mode_ack,
    output logic        mode_busy,
    output logic [1:0]  cur_mode,
    input  logic [9:0]  in_vertical,
`ifdef VGA_CTRL_PROG_EN
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [9:0]  wr_data,
`endif
    output logic [9:0]  hlimit,
    output logic [9:0]  hsync,
    output logic [9:0]  hbp,
    output logic [9:0]  hfp,
    output logic [9:0]  hlenght,
    output logic [9:0]  vlimit,
    output logic [9:0]  vsync,
    output logic [9:0]  vbp,
    output logic [9:0]  vfp,
    output logic [9:0]  vlenght,
    output logic        blank
);
    localparam int unsigned PW = 10;
    localparam int unsigned CW = 4;
    localparam logic [1:0]    DEF_MODE = 2'(DEFAULT_MODE);
    localparam logic [CW-1:0] SETTLE_N = CW'(FRAME_SETTLE);

    typedef struct packed {
        logic [PW-1:0] limit;
        logic [PW-1:0] sync;
        logic [PW-1:0] bp;
        logic [PW-1:0] fp;
        logic [PW-1:0] len;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
    } mode_par_t;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_PEND   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    // Fixed timing table, fields ordered {limit, sync, bp, fp, len}
    function automatic mode_par_t rom_params(input logic [1:0] m);
        mode_par_t p;
        p.h = {10'd799, 10'd96, 10'd48, 10'd16, 10'd640};
        case (m)
            2'd0:    p.v = {10'd524, 10'd2, 10'd33, 10'd10, 10'd480};
            2'd1:    p.v = {10'd448, 10'd2, 10'd60, 10'd37, 10'd350};
            2'd2:    p.v = {10'd448, 10'd2, 10'd35, 10'd12, 10'd400};
            default: begin
                p.h = {10'd27, 10'd4, 10'd4, 10'd4, 10'd16};
                p.v = {10'd6, 10'd1, 10'd1, 10'd1, 10'd4};
            end
        endcase
        return p;
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_cur;
    logic [1:0]    r_next;
    logic [PW-1:0] r_prev_v;
    mode_par_t     r_par;
    logic          r_blank;
    logic          r_busy;
    logic          r_ack;
    mode_par_t     w_next_par;
    logic          w_fb;

`ifdef VGA_CTRL_PROG_EN
    mode_par_t r_shadow;

    // Shadow copy of mode 3; only read when a switch into mode 3 is applied
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_shadow <= rom_params(2'd3);
        end else if (wr_en) begin
            case (wr_addr)
                4'd0:    r_shadow.h.limit <= wr_data;
                4'd1:    r_shadow.h.sync  <= wr_data;
                4'd2:    r_shadow.h.bp    <= wr_data;
                4'd3:    r_shadow.h.fp    <= wr_data;
                4'd4:    r_shadow.h.len   <= wr_data;
                4'd5:    r_shadow.v.limit <= wr_data;
                4'd6:    r_shadow.v.sync  <= wr_data;
                4'd7:    r_shadow.v.bp    <= wr_data;
                4'd8:    r_shadow.v.fp    <= wr_data;
                4'd9:    r_shadow.v.len   <= wr_data;
                default: ;
            endcase
        end
    end
`endif

    always_comb begin
        w_next_par = rom_params(r_next);
`ifdef VGA_CTRL_PROG_EN
        if (r_next == 2'd3) begin
            w_next_par = r_shadow;
        end
`endif
    end

    assign w_fb = (in_vertical == '0) && (r_prev_v != '0);

    // Mode FSM: accept in RUN, switch on a frame boundary, then blank for the settle frames
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= S_SETTLE;
            r_cnt    <= '0;
            r_cur    <= DEF_MODE;
            r_next   <= DEF_MODE;
            r_prev_v <= '0;
            r_par    <= rom_params(DEF_MODE);
            r_blank  <= 1'b1;
            r_busy   <= 1'b1;
            r_ack    <= 1'b0;
        end else begin
            r_prev_v <= in_vertical;
            r_ack    <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (mode_req) begin
                        r_ack  <= 1'b1;
                        r_next <= mode_sel;
                        if (mode_sel != r_cur) begin
                            r_state <= S_PEND;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_PEND: begin
                    if (w_fb) begin
                        r_par   <= w_next_par;
                        r_cur   <= r_next;
                        r_cnt   <= '0;
                        r_blank <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_N) begin
                        r_state <= S_RUN;
                        r_blank <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_fb) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_SETTLE;
                    r_cnt   <= '0;
                    r_blank <= 1'b1;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign mode_ack  = r_ack;
    assign mode_busy = r_busy;
    assign cur_mode  = r_cur;
    assign blank     = r_blank;
    assign hlimit    = r_par.h.limit;
    assign hsync     = r_par.h.sync;
    assign hbp       = r_par.h.bp;
    assign hfp       = r_par.h.fp;
    assign hlenght   = r_par.h.len;
    assign vlimit    = r_par.v.limit;
    assign vsync     = r_par.v.sync;
    assign vbp       = r_par.v.bp;
    assign vfp       = r_par.v.fp;
    assign vlenght   = r_par.v.len;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl: per-cycle comparison against a behavioural mode model
// plus directed checks of switching, settle deferral, same-mode requests and mid-switch reset.
module tb_vga_timing_ctrl;
    localparam int unsigned FS = 2;
    localparam int unsigned DM = 0;
    localparam int PH_RUN    = 0;
    localparam int PH_PEND   = 1;
    localparam int PH_SETTLE = 2;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       mode_ack;
    logic       mode_busy;
    logic [1:0] cur_mode;
    logic [9:0] in_vertical;
    logic [9:0] hlimit, hsync, hbp, hfp, hlenght;
    logic [9:0] vlimit, vsync, vbp, vfp, vlenght;
    logic       blank;
`ifdef VGA_CTRL_PROG_EN
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [9:0] wr_data;
`endif

    int n_checks;
    int n_fail;

    // Model: phase, applied mode, pending target, frames left to settle, live table entry
    int m_phase;
    int m_mode;
    int m_target;
    int m_left;
    int m_prev_v;
    bit m_ack;
    int m_tab [4][10];
    int m_live [10];
    int v_lim;

    always #5 clk_in = ~clk_in;

    vga_timing_ctrl #(.FRAME_SETTLE(FS), .DEFAULT_MODE(DM)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .mode_req    (mode_req),
        .mode_sel    (mode_sel),
        .mode_ack    (mode_ack),
        .mode_busy   (mode_busy),
        .cur_mode    (cur_mode),
        .in_vertical (in_vertical),
`ifdef VGA_CTRL_PROG_EN
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`endif
        .hlimit      (hlimit),
        .hsync       (hsync),
        .hbp         (hbp),
        .hfp         (hfp),
        .hlenght     (hlenght),
        .vlimit      (vlimit),
        .vsync       (vsync),
        .vbp         (vbp),
        .vfp         (vfp),
        .vlenght     (vlenght),
        .blank       (blank)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_dut();
        return 128'({mode_ack, mode_busy, cur_mode, blank,
                     hlimit, hsync, hbp, hfp, hlenght,
                     vlimit, vsync, vbp, vfp, vlenght});
    endfunction

    // Table rows are kept in the order {limit, sync, bp, len, fp} for H then V
    function automatic logic [127:0] pack_model();
        return 128'({m_ack, (m_phase != PH_RUN), 2'(m_mode), (m_phase == PH_SETTLE),
                     10'(m_live[0]), 10'(m_live[1]), 10'(m_live[2]), 10'(m_live[4]), 10'(m_live[3]),
                     10'(m_live[5]), 10'(m_live[6]), 10'(m_live[7]), 10'(m_live[9]), 10'(m_live[8])});
    endfunction

    function automatic int field_idx(input logic [3:0] a);
        case (a)
            4'd3:    return 4;
            4'd4:    return 3;
            4'd8:    return 9;
            4'd9:    return 8;
            default: return int'(a);
        endcase
    endfunction

    task automatic model_reset();
        m_tab[0] = '{799, 96, 48, 640, 16, 524, 2, 33, 480, 10};
        m_tab[1] = '{799, 96, 48, 640, 16, 448, 2, 60, 350, 37};
        m_tab[2] = '{799, 96, 48, 640, 16, 448, 2, 35, 400, 12};
        m_tab[3] = '{27, 4, 4, 16, 4, 6, 1, 1, 4, 1};
        m_live   = m_tab[DM];
        m_phase  = PH_SETTLE;
        m_left   = FS;
        m_mode   = DM;
        m_target = DM;
        m_prev_v = 0;
        m_ack    = 1'b0;
    endtask

    task automatic model_edge();
        bit fb;
        fb    = (int'(in_vertical) == 0) && (m_prev_v != 0);
        m_ack = 1'b0;
        case (m_phase)
            PH_RUN: begin
                if (mode_req) begin
                    m_ack    = 1'b1;
                    m_target = int'(mode_sel);
                    if (m_target != m_mode) m_phase = PH_PEND;
                end
            end
            PH_PEND: begin
                if (fb) begin
                    m_live  = m_tab[m_target];
                    m_mode  = m_target;
                    m_left  = FS;
                    m_phase = PH_SETTLE;
                end
            end
            default: begin
                if (m_left == 0) m_phase = PH_RUN;
                else if (fb) m_left--;
            end
        endcase
`ifdef VGA_CTRL_PROG_EN
        if (wr_en && wr_addr < 4'd10) m_tab[3][field_idx(wr_addr)] = int'(wr_data);
`endif
        m_prev_v = int'(in_vertical);
    endtask

    // Vertical position source: random frame heights, occasional stalls
    task automatic advance_v();
        if ($urandom_range(3, 0) != 0) begin
            if (int'(in_vertical) >= v_lim) begin
                in_vertical = '0;
                v_lim = int'($urandom_range(12, 2));
            end else begin
                in_vertical = in_vertical + 10'd1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        if (rst_in) model_reset();
        else model_edge();
        @(negedge clk_in);
        chk("cycle", pack_dut(), pack_model());
        advance_v();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while (mode_busy && n < max_cyc) begin
            step();
            n++;
        end
        chk("idle_reached", 128'(mode_busy), 128'(0));
    endtask

    task automatic request(input logic [1:0] sel, input int max_cyc,
                           output int lat, output bit b1, output bit b2);
        mode_req = 1'b1;
        mode_sel = sel;
        lat = 0;
        b1 = 1'b0;
        b2 = 1'b0;
        do begin
            b2 = b1;
            b1 = mode_busy;
            step();
            lat++;
        end while (!mode_ack && lat < max_cyc);
        chk("ack_seen", 128'(mode_ack), 128'(1));
        mode_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        #1;
        model_reset();
        chk("rst_async", pack_dut(), pack_model());
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        bit b1;
        bit b2;
        n_checks    = 0;
        n_fail      = 0;
        rst_in      = 1'b1;
        mode_req    = 1'b0;
        mode_sel    = 2'd0;
        in_vertical = '0;
        v_lim       = 5;
`ifdef VGA_CTRL_PROG_EN
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
`endif
        #1;
        model_reset();
        chk("rst_hlimit", 128'(hlimit), 128'(799));
        chk("rst_vlimit", 128'(vlimit), 128'(524));
        chk("rst_blank", 128'(blank), 128'(1));
        chk("rst_busy", 128'(mode_busy), 128'(1));
        chk("rst_mode", 128'(cur_mode), 128'(0));
        chk("rst_ack", 128'(mode_ack), 128'(0));
        @(negedge clk_in);
        rst_in = 1'b0;

        run_until_idle(500);
        chk("idle_blank", 128'(blank), 128'(0));
        chk("idle_hlimit", 128'(hlimit), 128'(799));

        // Switch to the small mode; applies only on a frame boundary
        request(2'd3, 10, lat, b1, b2);
        chk("ack_latency", 128'(lat), 128'(1));
        step();
        chk("ack_pulse", 128'(mode_ack), 128'(0));
        n = 0;
        while (cur_mode != 2'd3 && n < 300) begin
            step();
            n++;
        end
        chk("sw_hlimit", 128'(hlimit), 128'(27));
        chk("sw_vlimit", 128'(vlimit), 128'(6));
        chk("sw_blank", 128'(blank), 128'(1));
        chk("sw_mode", 128'(cur_mode), 128'(3));

        // Request during SETTLE is held off until RUN
        chk("settle_busy", 128'(mode_busy), 128'(1));
        request(2'd1, 500, lat, b1, b2);
        chk("settle_ack_after_run", 128'(b1), 128'(0));
        chk("settle_ack_first_run", 128'(b2), 128'(1));
        run_until_idle(500);

        // Same-mode request: ack only
        request(2'd1, 10, lat, b1, b2);
        chk("same_ack_latency", 128'(lat), 128'(1));
        chk("same_busy", 128'(mode_busy), 128'(0));
        chk("same_blank", 128'(blank), 128'(0));
        chk("same_vlimit", 128'(vlimit), 128'(448));

        // Reset while a switch to mode 2 is pending
        request(2'd0, 10, lat, b1, b2);
        run_until_idle(500);
        request(2'd2, 10, lat, b1, b2);
        chk("pend_busy", 128'(mode_busy), 128'(1));
        do_reset();
        chk("pend_rst_hlimit", 128'(hlimit), 128'(799));
        chk("pend_rst_vlimit", 128'(vlimit), 128'(524));
        chk("pend_rst_blank", 128'(blank), 128'(1));
        run_until_idle(500);
        chk("pend_rst_mode", 128'(cur_mode), 128'(0));
        chk("pend_rst_vlen", 128'(vlenght), 128'(480));

`ifdef VGA_CTRL_PROG_EN
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 10'd31;
        step();
        wr_en = 1'b0;
        chk("prog_live_untouched", 128'(hlimit), 128'(799));
        request(2'd3, 10, lat, b1, b2);
        run_until_idle(500);
        chk("prog_hlimit", 128'(hlimit), 128'(31));
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 10'd5;
        step();
        wr_en = 1'b0;
        request(2'd3, 10, lat, b1, b2);
        step();
        chk("prog_no_reload", 128'(hlimit), 128'(31));
`endif

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            step();
            if (mode_req && mode_ack) begin
                mode_req = 1'b0;
            end else if (!mode_req && $urandom_range(15, 0) == 0) begin
                mode_req = 1'b1;
                mode_sel = 2'($urandom_range(3, 0));
            end
`ifdef VGA_CTRL_PROG_EN
            wr_en   = ($urandom_range(9, 0) == 0);
            wr_addr = 4'($urandom_range(15, 0));
            wr_data = 10'($urandom);
`endif
            if ($urandom_range(599, 0) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
